score_tracker: RTL
==================

Name: score_tracker

Overview:
- Gameplay scoring stage, directly upstream of the high-score checker.
- Converts per-note hit/miss strobes from the note-judging logic into a 2-digit BCD score, plus combo and miss counters.
- The 8-bit score feeds the high-score checker, which samples it while mode is FINISH. The score therefore holds stable outside PLAY.
- Also raises a sticky fail flag after too many misses, for the top-level game FSM.

Parameters:
- PLAY_MODE, 3'b010, mode encoding in which scoring is active.
- MAX_MISSES, 4'd5, miss count at which fail asserts (legal range 1..15).
- COMBO_T1, 4'd4, combo threshold for 2-point hits.
- COMBO_T2, 4'd8, combo threshold for 3-point hits (COMBO_T2 > COMBO_T1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- mode  input  3  game FSM state; FINISH = 3'b101.
- hit  input  1  one-cycle strobe, note judged correct.
- miss  input  1  one-cycle strobe, note missed or wrong.
- score  output  8  packed BCD, tens in [7:4], ones in [3:0], range 8'h00..8'h99.
- combo  output  4  consecutive hits since last miss, saturates at 15.
- miss_count  output  4  misses this game, saturates at 15.
- fail  output  1  sticky, high once miss_count >= MAX_MISSES.

Behaviour:
- Reset (async, n_rst=0): score=8'h00, combo=0, miss_count=0, fail=0, internal prev_mode=3'b000. Takes effect immediately, including mid-game.
- All outputs are registered.
- Hit/miss effects appear on the outputs one clock after the strobe edge.
- prev_mode register holds last cycle's mode.
- Game start condition: mode==PLAY_MODE and prev_mode!=PLAY_MODE.
  - Clears score, combo, miss_count and fail on that edge.
  - hit/miss in that same cycle are ignored.
- Active scoring: mode==PLAY_MODE, not a start cycle, fail==0.
- Outside active scoring (any other mode, including FINISH, or fail==1):
  - hit and miss are ignored.
  - All outputs hold their value.
- Hit (hit=1, miss=0) while active:
  - Points are chosen from combo before the increment: 1 if combo<COMBO_T1, 2 if combo<COMBO_T2, else 3.
  - score <= BCD_sat(score + points).
  - combo <= min(combo+1, 15).
- Miss (miss=1, regardless of hit) while active:
  - combo <= 0 and miss_count <= min(miss_count+1, 15). Score is unchanged.
  - Simultaneous hit+miss is treated as a miss.
- fail <= 1 on the edge where the updated miss_count reaches MAX_MISSES.
  - fail stays set until reset or the next game start.
- BCD arithmetic:
  - Ones digit: add points. If the result is >9, subtract 10 and carry 1.
  - Tens digit: add carry. If the result is >9, force the score to 8'h99 (saturate).
  - Score never holds a nibble above 9 and never wraps.

Test Plan:
- Reset with no stimulus:
  - Required: score=8'h00, combo=0, miss_count=0, fail=0.
  - Assert n_rst low mid-game at score 8'h27: outputs go to zero immediately, not waiting for a clock edge.
- mode=PLAY, 9 consecutive hit pulses:
  - Score after hits 1-4 = 8'h01, 8'h02, 8'h03, 8'h04.
  - After hit 8: score 8'h12. After hit 9: score 8'h15, combo=9.
- BCD carry and saturation:
  - From score 8'h09 with combo 0, one hit gives 8'h10 (not 8'h0A).
  - Drive to 8'h98 with combo>=8; the next hit gives 8'h99.
  - A further hit keeps 8'h99.
- Miss handling with defaults:
  - Hit then miss: combo returns to 0, miss_count=1.
  - Simultaneous hit+miss: score unchanged, combo=0, miss_count=2.
  - Five total misses: fail=1.
  - Subsequent hits leave score unchanged.
- Mode gating and handoff:
  - Reach score 8'h15, then mode=3'b101 (FINISH) and pulse hit 3 times: score holds 8'h15.
  - Return mode to PLAY with a hit in the same cycle: next edge gives score 8'h00, combo 0, fail 0 (hit ignored).

Source files
------------

// File: rtl/score_tracker.sv
// Gameplay scoring: turns hit/miss strobes into a saturating 2-digit BCD score,
// a combo counter, a miss counter and a sticky fail flag for the game FSM.
module score_tracker #(
    parameter logic [2:0] PLAY_MODE  = 3'b010,
    parameter logic [3:0] MAX_MISSES = 4'd5,
    parameter logic [3:0] COMBO_T1   = 4'd4,
    parameter logic [3:0] COMBO_T2   = 4'd8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] mode,
    input  logic       hit,
    input  logic       miss,
    output logic [7:0] score,
    output logic [3:0] combo,
    output logic [3:0] miss_count,
    output logic       fail
);

    logic [2:0] prev_mode_reg;
    logic [7:0] score_reg, score_next;
    logic [3:0] combo_reg, combo_next;
    logic [3:0] miss_count_reg, miss_count_next;
    logic       fail_reg, fail_next;

    logic       start_game;
    logic       active;
    logic [1:0] points;
    logic [4:0] ones_sum;
    logic       ones_carry;
    logic [3:0] ones_digit;
    logic [4:0] tens_sum;
    logic [7:0] score_add;
    logic [3:0] miss_count_inc;

    assign start_game = (mode == PLAY_MODE) && (prev_mode_reg != PLAY_MODE);
    assign active     = (mode == PLAY_MODE) && !start_game && !fail_reg;

    // Points depend on the combo length before this hit is counted.
    always_comb begin
        points = 2'd3;
        if (combo_reg < COMBO_T1) begin
            points = 2'd1;
        end else if (combo_reg < COMBO_T2) begin
            points = 2'd2;
        end
    end

    // Packed-BCD add; a tens overflow pins the score at 99 instead of wrapping.
    always_comb begin
        ones_sum   = {1'b0, score_reg[3:0]} + {3'b000, points};
        ones_carry = (ones_sum > 5'd9);
        ones_digit = ones_carry ? (ones_sum[3:0] - 4'd10) : ones_sum[3:0];
        tens_sum   = {1'b0, score_reg[7:4]} + {4'b0000, ones_carry};
        score_add  = (tens_sum > 5'd9) ? 8'h99 : {tens_sum[3:0], ones_digit};
    end

    assign miss_count_inc = (miss_count_reg == 4'hF) ? 4'hF : (miss_count_reg + 4'd1);

    always_comb begin
        score_next      = score_reg;
        combo_next      = combo_reg;
        miss_count_next = miss_count_reg;
        fail_next       = fail_reg;
        if (start_game) begin
            score_next      = 8'h00;
            combo_next      = 4'd0;
            miss_count_next = 4'd0;
            fail_next       = 1'b0;
        end else if (active) begin
            if (miss) begin
                combo_next      = 4'd0;
                miss_count_next = miss_count_inc;
                fail_next       = (miss_count_inc >= MAX_MISSES);
            end else if (hit) begin
                score_next = score_add;
                combo_next = (combo_reg == 4'hF) ? 4'hF : (combo_reg + 4'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_mode_reg  <= 3'b000;
            score_reg      <= 8'h00;
            combo_reg      <= 4'd0;
            miss_count_reg <= 4'd0;
            fail_reg       <= 1'b0;
        end else begin
            prev_mode_reg  <= mode;
            score_reg      <= score_next;
            combo_reg      <= combo_next;
            miss_count_reg <= miss_count_next;
            fail_reg       <= fail_next;
        end
    end

    assign score      = score_reg;
    assign combo      = combo_reg;
    assign miss_count = miss_count_reg;
    assign fail       = fail_reg;

endmodule
